// File: rtl/pipe_addsub_vr.sv
// pipe_addsub_vr: three-stage valid/ready pipeline returning op1 - (op1 + op2) with carry/borrow flags.
// Define PIPE_ADDSUB_STATS_EN to build the txn_count/stall_count counters; otherwise both read 0.
module pipe_addsub_vr #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_op1,
   input  logic [WIDTH-1:0] in_op2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_carry,
   output logic             out_borrow,
   output logic [31:0]      txn_count,
   output logic [31:0]      stall_count
);
   logic v1, v2, v3, adv1, adv2, adv3;
   logic [WIDTH-1:0] s1_op1, s1_op2, s2_op1, s3_res;
   logic [WIDTH:0] s2_sum;
   logic s3_carry, s3_borrow;

   // a stage moves when its successor moves or when it holds a bubble
   always_comb begin
      adv3 = out_ready || !v3;
      adv2 = adv3 || !v2;
      adv1 = adv2 || !v1;
   end

   assign in_ready   = adv1;
   assign out_valid  = v3;
   assign out_res    = s3_res;
   assign out_carry  = s3_carry;
   assign out_borrow = s3_borrow;

   // valid bits shift with their stage; bubbles travel as v=0
   always_ff @(posedge clk) begin
      if (reset) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         if (adv1) v1 <= in_valid;
         if (adv2) v2 <= v1;
         if (adv3) v3 <= v2;
      end
   end

   // payloads only load real entries, so outputs stay put across bubbles
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_op1    <= '0;
         s1_op2    <= '0;
         s2_op1    <= '0;
         s2_sum    <= '0;
         s3_res    <= '0;
         s3_carry  <= 1'b0;
         s3_borrow <= 1'b0;
      end else begin
         if (adv1 && in_valid) begin
            s1_op1 <= in_op1;
            s1_op2 <= in_op2;
         end
         if (adv2 && v1) begin
            s2_op1 <= s1_op1;
            s2_sum <= {1'b0, s1_op1} + {1'b0, s1_op2};
         end
         if (adv3 && v2) begin
            s3_res    <= s2_op1 - s2_sum[WIDTH-1:0];
            s3_carry  <= s2_sum[WIDTH];
            s3_borrow <= s2_op1 < s2_sum[WIDTH-1:0];
         end
      end
   end

`ifdef PIPE_ADDSUB_STATS_EN
   logic [31:0] txn_q, stall_q;

   // accepted-transaction and output-stall counters, wrapping at 2^32
   always_ff @(posedge clk) begin
      if (reset) begin
         txn_q   <= '0;
         stall_q <= '0;
      end else begin
         if (in_valid && adv1) txn_q <= txn_q + 32'd1;
         if (v3 && !out_ready) stall_q <= stall_q + 32'd1;
      end
   end

   assign txn_count   = txn_q;
   assign stall_count = stall_q;
`else
   assign txn_count   = '0;
   assign stall_count = '0;
`endif
endmodule

// File: tb/tb_pipe_addsub_vr.sv
// tb_pipe_addsub_vr: directed and randomised-handshake bench for pipe_addsub_vr with an in-order scoreboard.
module tb_pipe_addsub_vr;
   localparam int W = 32;
`ifdef PIPE_ADDSUB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, in_valid, in_ready, out_valid, out_ready, out_carry, out_borrow;
   logic [W-1:0] in_op1, in_op2, out_res;
   logic [31:0] txn_count, stall_count;
   logic acc;
   logic [W+1:0] q[$];
   int tests = 0;
   int fails = 0;
   int n;

   pipe_addsub_vr #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op1(in_op1), .in_op2(in_op2),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
      .out_carry(out_carry), .out_borrow(out_borrow),
      .txn_count(txn_count), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference: {carry, borrow, res}
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return {s[W], a < s[W-1:0], a - s[W-1:0]};
   endfunction

   // settle, record both handshakes of this cycle, then cross the edge
   task automatic step();
      #1;
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(in_op1, in_op2));
      if (out_valid && out_ready) begin
         if (q.size() == 0) check("extra_out", 1, 0);
         else check("sb", {out_carry, out_borrow, out_res}, q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      q.delete();
   endtask

   task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_res, input logic e_c, input logic e_b);
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_op1 = a;
      in_op2 = b;
      step();
      check({tag, "_acc"}, acc, 1);
      in_valid = 1'b0;
      step();
      check({tag, "_lat_early"}, out_valid, 0);
      step();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_res"}, out_res, e_res);
      check({tag, "_carry"}, out_carry, e_c);
      check({tag, "_borrow"}, out_borrow, e_b);
      step();
      check({tag, "_empty"}, q.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_op1 = '0;
      in_op2 = '0;
      reset_dut();
      check("rst_valid", out_valid, 0);
      check("rst_res", out_res, 0);
      check("rst_carry", out_carry, 0);
      check("rst_borrow", out_borrow, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_txn", txn_count, 0);
      check("rst_stall", stall_count, 0);

      run_one("basic", 32'd5, 32'd3, 32'hFFFF_FFFD, 1'b0, 1'b1);
      run_one("wrap", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run_one("zero", 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);

      // streaming: 8 back-to-back pairs, results visible in cycles 3..10
      out_ready = 1'b1;
      in_op1 = 32'd100;
      for (int c = 0; c < 13; c++) begin
         in_valid = (c < 8);
         in_op2 = c + 1;
         #1;
         check("strm_ready", in_ready, 1);
         check("strm_valid", out_valid, (c >= 3 && c < 11));
         if (c >= 3 && c < 11) check("strm_res", out_res, 32'hFFFF_FFFF - (c - 3));
         step();
      end
      check("strm_empty", q.size(), 0);

      // back-pressure: 3 accepts, then 10 stalled cycles with a stable head
      reset_dut();
      in_valid = 1'b1;
      in_op1 = 32'd10;
      in_op2 = 32'd1;
      n = 0;
      for (int c = 0; c < 13; c++) begin
         if (c >= 3) begin
            check("bp_valid", out_valid, 1);
            check("bp_head", out_res, 32'hFFFF_FFFF);
         end
         step();
         if (acc) begin
            n++;
            in_op2 = n + 1;
         end
      end
      check("bp_accepts", n, 3);
      check("bp_in_ready", in_ready, 0);
      check("bp_txn", txn_count, STATS ? 3 : 0);
      check("bp_stall", stall_count, STATS ? 10 : 0);
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 1);
      for (int c = 0; c < 3; c++) begin
         step();
         check("bp_refill_acc", acc, 1);
         in_op2 = in_op2 + 1;
      end
      in_valid = 1'b0;
      for (int c = 0; c < 20 && q.size() != 0; c++) step();
      check("bp_drained", q.size(), 0);

      // bubbles: random valid/ready patterns against the scoreboard
      reset_dut();
      n = 0;
      for (int c = 0; c < 20000 && n < 1000; c++) begin
         if (!in_valid) begin
            in_valid = $urandom_range(1, 0) == 1;
            in_op1 = $urandom;
            in_op2 = $urandom;
         end
         out_ready = $urandom_range(1, 0) == 1;
         step();
         if (acc) begin
            n++;
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check("bub_count", n, 1000);
      out_ready = 1'b1;
      for (int c = 0; c < 10 && q.size() != 0; c++) step();
      check("bub_drained", q.size(), 0);

      // reset mid-flight discards two in-flight pairs
      reset_dut();
      in_valid = 1'b1;
      in_op1 = 32'd9;
      in_op2 = 32'd4;
      step();
      step();
      in_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      q.delete();
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         check("mid_valid", out_valid, 0);
         step();
      end
      check("mid_in_ready", in_ready, 1);
      check("mid_txn", txn_count, 0);
      check("mid_stall", stall_count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
